// File: rtl/mcp4922_pkg.sv
// Shared types, sizes and the command-word builder for the MCP4922 DAC writer.
package mcp4922_pkg;
    localparam int DAC_N      = 12;
    localparam int FRAME_BITS = 16;
    localparam int CHANNELS   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FRAME  = 2'd1,
        ST_CS_GAP = 2'd2,
        ST_LDAC   = 2'd3
    } dac_state_t;

    function automatic logic [FRAME_BITS-1:0] build_cmd(
        input logic             ch,
        input logic [DAC_N-1:0] data,
        input logic             cfg_buf,
        input logic             cfg_ga_n,
        input logic             cfg_shdn_n
    );
        return {ch, cfg_buf, cfg_ga_n, cfg_shdn_n, data};
    endfunction
endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period timer: down-counter that pulses o_tick once every SCLK_DIV cycles.
module spi_half_tick #(
    parameter int SCLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);
    localparam int            CW     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SCLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // A restart loads the full period so the first tick lands exactly SCLK_DIV cycles later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= RELOAD;
        end else if (i_restart || (r_cnt == '0)) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_tick = (r_cnt == '0);
endmodule

// File: rtl/mcp4922_dac.sv
// MCP4922 writer: takes a sample pair, shifts out channel A then B frames, then strobes LDAC_n.
// state     | meaning
// ST_IDLE   | ready for a pair, all SPI lines idle
// ST_FRAME  | CS_n low, 16 SCLK periods plus one trailing low half-period
// ST_CS_GAP | CS_n high for one half-period between/after frames
// ST_LDAC   | LDAC_n low for one half-period, both outputs update
module mcp4922_dac
    import mcp4922_pkg::*;
#(
    parameter int   SCLK_DIV = 2,
    parameter logic BUF      = 1'b0,
    parameter logic GA_n     = 1'b1,
    parameter logic SHDN_n   = 1'b1
) (
    input  logic                           CLK50,
    input  logic                           reset,
    input  logic [CHANNELS-1:0][DAC_N-1:0] dac_in,
    input  logic                           dac_valid,
    output logic                           dac_ready,
    output logic                           SPI_OUT,
    output logic                           SCLK,
    output logic                           CS_n,
    output logic                           LDAC_n
);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    dac_state_t            r_state;
    dac_state_t            w_state_nxt;
    logic                  w_tick;
    logic                  w_restart;
    logic                  w_enter_frame;
    logic                  r_ch;
    logic                  r_sclk;
    logic                  r_done;
    logic [3:0]            r_bit_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [DAC_N-1:0]      r_sample_b;

    spi_half_tick #(.SCLK_DIV(SCLK_DIV)) u_half_tick (
        .i_clk     (CLK50),
        .i_rst     (reset),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_ff @(posedge CLK50 or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (dac_valid) w_state_nxt = ST_FRAME;
            ST_FRAME:  if (w_tick && !r_sclk && r_done) w_state_nxt = ST_CS_GAP;
            ST_CS_GAP: if (w_tick) w_state_nxt = r_ch ? ST_LDAC : ST_FRAME;
            ST_LDAC:   if (w_tick) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        dac_ready = 1'b0;
        CS_n      = 1'b1;
        LDAC_n    = 1'b1;
        SPI_OUT   = 1'b0;
        case (r_state)
            ST_IDLE:  dac_ready = 1'b1;
            ST_FRAME: begin
                CS_n    = 1'b0;
                SPI_OUT = r_shift[FRAME_BITS-1];
            end
            ST_LDAC:  LDAC_n = 1'b0;
            default:  ;
        endcase
    end

    assign SCLK          = r_sclk;
    assign w_restart     = (w_state_nxt != r_state);
    assign w_enter_frame = (w_state_nxt == ST_FRAME) && (r_state != ST_FRAME);

    // Shift only on falling edges; after the 16th falling edge r_done holds SCLK low until CS_n rises.
    always_ff @(posedge CLK50 or posedge reset) begin
        if (reset) begin
            r_ch       <= 1'b0;
            r_sclk     <= 1'b0;
            r_done     <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_sample_b <= '0;
        end else if (w_enter_frame) begin
            r_sclk    <= 1'b0;
            r_done    <= 1'b0;
            r_bit_cnt <= LAST_BIT;
            r_ch      <= (r_state != ST_IDLE);
            if (r_state == ST_IDLE) begin
                r_sample_b <= dac_in[1];
                r_shift    <= build_cmd(1'b0, dac_in[0], BUF, GA_n, SHDN_n);
            end else begin
                r_shift    <= build_cmd(1'b1, r_sample_b, BUF, GA_n, SHDN_n);
            end
        end else if ((r_state == ST_FRAME) && w_tick) begin
            if (!r_sclk) begin
                if (!r_done) r_sclk <= 1'b1;
            end else begin
                r_sclk <= 1'b0;
                if (r_bit_cnt != '0) begin
                    r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt - 4'd1;
                end else begin
                    r_done <= 1'b1;
                end
            end
        end
    end
endmodule
